// File: rtl/spi_txn_arbiter_if.sv
// Requester-side and SPI-master-side signal bundle for spi_txn_arbiter.
// The master modport is the arbiter's view; the slave modport is the environment's.
interface spi_txn_arbiter_if #(
  parameter int NREQ = 2
) ();
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_len;
  logic [8*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic [7:0]        rdata;
  logic              spi_start;
  logic [7:0]        spi_wdata;
  logic              spi_ready;
  logic [7:0]        spi_rdata;
  logic [NREQ-1:0]   spi_cs_n;

  modport master (
    input  req, req_len, req_wdata, spi_ready, spi_rdata,
    output grant, ack, done, err, rdata, spi_start, spi_wdata, spi_cs_n
  );

  modport slave (
    output req, req_len, req_wdata, spi_ready, spi_rdata,
    input  grant, ack, done, err, rdata, spi_start, spi_wdata, spi_cs_n
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that shares one byte-level SPI master between NREQ requesters,
// sequencing CS setup, N byte exchanges and CS hold for each granted transaction.
module spi_txn_arbiter #(
  parameter int NREQ     = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic               clk,
  input  logic               resetn,
  spi_txn_arbiter_if.master  bus
);

  localparam int IW = $clog2(NREQ);
  // SETUP plus the START cycle together give CS_SETUP cycles of CS before the strobe.
  localparam logic [3:0] SETUP_LAST = 4'((CS_SETUP > 1) ? CS_SETUP - 2 : 0);
  localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD - 1);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, START, WAIT_ACK, WAIT_DONE, HOLD
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   g;
  logic [3:0]      len;
  logic [3:0]      phase_cnt;
  logic [7:0]      tmo_cnt;
  logic [NREQ-1:0] grant_r;
  logic [NREQ-1:0] ack_r;
  logic [NREQ-1:0] done_r;
  logic [NREQ-1:0] err_r;
  logic [NREQ-1:0] cs_n_r;
  logic [7:0]      rdata_r;
  logic [7:0]      spi_wdata_r;
  logic            spi_start_r;

  logic [IW-1:0]   pick;
  logic [3:0]      pick_len;
  logic [7:0]      cur_wdata;

  // First set request searching upward from ptr+1; the outer loop runs from the
  // farthest distance down so the nearest candidate is written last.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] sel;
    sel = ptr;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r[i] && ((int'(ptr) + k) % NREQ) == i) sel = IW'(i);
      end
    end
    return sel;
  endfunction

  always_comb begin
    pick      = rr_pick(bus.req, rr_ptr);
    pick_len  = '0;
    cur_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) pick_len = bus.req_len[4*i +: 4];
      if (g == IW'(i))    cur_wdata = bus.req_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      rr_ptr      <= IW'(NREQ - 1);
      g           <= '0;
      len         <= '0;
      phase_cnt   <= '0;
      tmo_cnt     <= '0;
      grant_r     <= '0;
      ack_r       <= '0;
      done_r      <= '0;
      err_r       <= '0;
      cs_n_r      <= '1;
      rdata_r     <= '0;
      spi_wdata_r <= '0;
      spi_start_r <= 1'b0;
    end else begin
      ack_r       <= '0;
      done_r      <= '0;
      err_r       <= '0;
      spi_start_r <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            g         <= pick;
            len       <= pick_len;
            grant_r   <= NREQ'(1) << pick;
            cs_n_r    <= ~(NREQ'(1) << pick);
            phase_cnt <= '0;
            state     <= (CS_SETUP == 1) ? START : SETUP;
          end
        end
        SETUP: begin
          if (phase_cnt == SETUP_LAST) state <= START;
          else                         phase_cnt <= phase_cnt + 4'd1;
        end
        START: begin
          spi_start_r <= 1'b1;
          spi_wdata_r <= cur_wdata;
          tmo_cnt     <= '0;
          state       <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!bus.spi_ready) begin
            tmo_cnt <= '0;
            state   <= WAIT_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            cs_n_r  <= '1;
            err_r   <= grant_r;
            grant_r <= '0;
            rr_ptr  <= g;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (bus.spi_ready) begin
            rdata_r <= bus.spi_rdata;
            ack_r   <= grant_r;
            if (len != 4'd0) begin
              len   <= len - 4'd1;
              state <= START;
            end else begin
              phase_cnt <= '0;
              state     <= HOLD;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            cs_n_r  <= '1;
            err_r   <= grant_r;
            grant_r <= '0;
            rr_ptr  <= g;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (phase_cnt == HOLD_LAST) begin
            cs_n_r  <= '1;
            done_r  <= grant_r;
            grant_r <= '0;
            rr_ptr  <= g;
            state   <= IDLE;
          end else begin
            phase_cnt <= phase_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the granted slave may ever see its chip select low.
  cs_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(~cs_n_r));

  assign bus.grant     = grant_r;
  assign bus.ack       = ack_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.rdata     = rdata_r;
  assign bus.spi_start = spi_start_r;
  assign bus.spi_wdata = spi_wdata_r;
  assign bus.spi_cs_n  = cs_n_r;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: echoing SPI master model, requester reactions
// on the falling edge, and hand-computed expectations for each scenario.
module tb_spi_txn_arbiter;
  localparam int NREQ     = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int TIMEOUT  = 255;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  spi_txn_arbiter_if #(.NREQ(NREQ)) bus ();

  spi_txn_arbiter #(
    .NREQ(NREQ), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI master: echoes the tx byte, ready low for two falling edges after a start.
  bit master_dead = 1'b0;
  initial begin
    bit         busy;
    int         cnt;
    logic [7:0] wl;
    busy = 1'b0; cnt = 0; wl = 8'h00;
    bus.spi_ready = 1'b1;
    bus.spi_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (busy) begin
        if (cnt == 0) begin
          bus.spi_ready = 1'b1;
          bus.spi_rdata = wl;
          busy = 1'b0;
        end else begin
          cnt--;
        end
      end else if (bus.spi_start && !master_dead) begin
        bus.spi_ready = 1'b0;
        wl   = bus.spi_wdata;
        busy = 1'b1;
        cnt  = 1;
      end
    end
  end

  int         cyc, n_start, n_ack, t_cs, t_start, t_ack, t_done, t_err, cs_bad;
  int         n_done[2];
  int         n_err[2];
  logic [1:0] prev_grant, cs_end;
  logic [1:0] gseq[$];
  logic [7:0] rq[$];
  logic [7:0] wq0[$];
  logic [7:0] wq1[$];
  bit         hold_req, drop_first_ack;

  function automatic logic [7:0] rq_at(input int i);
    if (i < rq.size()) return rq[i];
    return 8'h00;
  endfunction

  function automatic logic [1:0] gseq_at(input int i);
    if (i < gseq.size()) return gseq[i];
    return 2'b00;
  endfunction

  task automatic clr();
    n_start = 0; n_ack = 0; cs_bad = 0;
    t_cs = -1; t_start = -1; t_ack = -1; t_done = -1; t_err = -1;
    n_done[0] = 0; n_done[1] = 0; n_err[0] = 0; n_err[1] = 0;
    cs_end = 2'b00;
    gseq.delete(); rq.delete(); wq0.delete(); wq1.delete();
    hold_req = 1'b0; drop_first_ack = 1'b0;
  endtask

  // One falling edge: observe outputs and react as the requesters would.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.spi_start) begin
      n_start++;
      if (t_start < 0) t_start = cyc;
    end
    if (t_cs < 0 && bus.spi_cs_n != 2'b11) t_cs = cyc;
    if (bus.grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(bus.grant);
    prev_grant = bus.grant;
    if (~bus.spi_cs_n != bus.grant) cs_bad++;
    if (bus.ack != 2'b00) begin
      n_ack++;
      t_ack = cyc;
      rq.push_back(bus.rdata);
    end
    if (bus.ack[0] && wq0.size() > 0) bus.req_wdata[7:0]  = wq0.pop_front();
    if (bus.ack[1] && wq1.size() > 0) bus.req_wdata[15:8] = wq1.pop_front();
    if (bus.ack[0] && drop_first_ack) begin
      bus.req[0] = 1'b0;
      drop_first_ack = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (bus.done[i]) begin
        n_done[i]++;
        t_done = cyc;
        cs_end = bus.spi_cs_n;
        if (!hold_req) bus.req[i] = 1'b0;
      end
      if (bus.err[i]) begin
        n_err[i]++;
        t_err = cyc;
        cs_end = bus.spi_cs_n;
        if (!hold_req) bus.req[i] = 1'b0;
      end
    end
  endtask

  task automatic run_until(input string tag, input int n_end, input int budget);
    int k;
    k = 0;
    while ((n_done[0] + n_done[1] + n_err[0] + n_err[1]) < n_end && k < budget) begin
      step();
      k++;
    end
    chk_vec({tag, "_completions"}, n_done[0] + n_done[1] + n_err[0] + n_err[1], n_end);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    prev_grant = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    bus.req = '0; bus.req_len = '0; bus.req_wdata = '0;
    cyc = 0; prev_grant = 2'b00;
    clr();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk_vec("rst_grant", bus.grant, 2'b00);
    chk_vec("rst_cs_n", bus.spi_cs_n, 2'b11);
    chk_vec("rst_start", bus.spi_start, 1'b0);
    chk_vec("rst_ack", bus.ack, 2'b00);
    chk_vec("rst_done_err", {bus.done, bus.err}, 4'b0000);
    chk_vec("rst_rdata", bus.rdata, 8'h00);
    chk_vec("rst_spi_wdata", bus.spi_wdata, 8'h00);
    resetn = 1'b1;

    // Single one-byte transaction
    clr();
    bus.req_len = '0;
    bus.req_wdata[7:0] = 8'hA5;
    bus.req = 2'b01;
    run_until("t1", 1, 100);
    step(); step();
    chk_vec("t1_setup_cycles", t_start - t_cs, CS_SETUP);
    chk_vec("t1_acks", n_ack, 1);
    chk_vec("t1_rdata", rq_at(0), 8'hA5);
    chk_vec("t1_hold_cycles", t_done - t_ack, CS_HOLD);
    chk_vec("t1_done0", n_done[0], 1);
    chk_vec("t1_cs_at_done", cs_end, 2'b11);
    chk_vec("t1_cs_track", cs_bad, 0);

    // Four-byte burst
    clr();
    bus.req_len[3:0] = 4'd3;
    bus.req_wdata[7:0] = 8'h11;
    wq0.push_back(8'h22); wq0.push_back(8'h33); wq0.push_back(8'h44);
    bus.req = 2'b01;
    run_until("t2", 1, 200);
    chk_vec("t2_starts", n_start, 4);
    chk_vec("t2_acks", n_ack, 4);
    for (int i = 0; i < 4; i++)
      chk_vec($sformatf("t2_rdata%0d", i), rq_at(i), 8'h11 * (i + 1));
    chk_vec("t2_cs_track", cs_bad, 0);
    chk_vec("t2_done0", n_done[0], 1);
    chk_vec("t2_errs", n_err[0] + n_err[1], 0);

    // Round-robin with both requests held
    do_reset();
    clr();
    hold_req = 1'b1;
    bus.req_len = '0;
    bus.req_wdata = {8'hB0, 8'hA0};
    bus.req = 2'b11;
    run_until("t3", 4, 300);
    bus.req = 2'b00;
    repeat (3) step();
    chk_vec("t3_grant_count", gseq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_vec($sformatf("t3_grant%0d", i), gseq_at(i), (i % 2 == 0) ? 2'b01 : 2'b10);
    chk_vec("t3_done0", n_done[0], 2);
    chk_vec("t3_done1", n_done[1], 2);

    // Timeout with an unresponsive master
    clr();
    master_dead = 1'b1;
    bus.req_len = '0;
    bus.req_wdata[7:0] = 8'h77;
    bus.req = 2'b01;
    run_until("t4", 1, 400);
    master_dead = 1'b0;
    chk_vec("t4_err_latency", t_err - t_start, TIMEOUT);
    chk_vec("t4_cs_at_err", cs_end, 2'b11);
    chk_vec("t4_err0", n_err[0], 1);
    chk_vec("t4_acks", n_ack, 0);
    chk_vec("t4_dones", n_done[0] + n_done[1], 0);

    // Reset during WAIT_DONE of byte 2 of 4
    clr();
    bus.req_len[3:0] = 4'd3;
    bus.req_wdata[7:0] = 8'h31;
    wq0.push_back(8'h32); wq0.push_back(8'h33); wq0.push_back(8'h34);
    bus.req = 2'b01;
    for (int k = 0; k < 200 && n_start < 2; k++) step();
    chk_vec("t5_second_start", n_start, 2);
    step();
    resetn = 1'b0;
    bus.req = 2'b00;
    #1;
    chk_vec("t5_cs_async", bus.spi_cs_n, 2'b11);
    chk_vec("t5_grant_async", bus.grant, 2'b00);
    chk_vec("t5_acks_before_rst", n_ack, 1);
    repeat (2) step();
    resetn = 1'b1;
    prev_grant = 2'b00;
    repeat (4) step();
    chk_vec("t5_no_done", n_done[0] + n_done[1], 0);
    chk_vec("t5_no_err", n_err[0] + n_err[1], 0);

    clr();
    bus.req_len = '0;
    bus.req_wdata[15:8] = 8'h3C;
    bus.req = 2'b10;
    run_until("t5b", 1, 100);
    chk_vec("t5b_grant", gseq_at(0), 2'b10);
    chk_vec("t5b_rdata", rq_at(0), 8'h3C);
    chk_vec("t5b_done1", n_done[1], 1);
    chk_vec("t5b_cs_track", cs_bad, 0);

    // Request dropped after the first ack of a three-byte transaction
    clr();
    bus.req_len[3:0] = 4'd2;
    bus.req_wdata[7:0] = 8'h01;
    wq0.push_back(8'h02); wq0.push_back(8'h03);
    drop_first_ack = 1'b1;
    bus.req = 2'b01;
    run_until("t6", 1, 150);
    repeat (10) step();
    chk_vec("t6_acks", n_ack, 3);
    for (int i = 0; i < 3; i++)
      chk_vec($sformatf("t6_rdata%0d", i), rq_at(i), i + 1);
    chk_vec("t6_done0", n_done[0], 1);
    chk_vec("t6_grant_count", gseq.size(), 1);
    chk_vec("t6_grant_idle", bus.grant, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
